// File: rtl/mips_pkg.sv
// Shared constants for the MIPS multi-cycle control unit and the datapath ALU decoder:
// machine-cycle codes, opcode/funct values, ALU control, ALU B-source and PC-source codes.
package mips_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EXEC   = 4'd3,
        ST_WB     = 4'd4,
        ST_DUMMY  = 4'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_OR  = 6'h25;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLL = 4'd4;
    localparam logic [3:0] ALU_LUI = 4'd5;

    localparam logic [1:0] SRCB_RT   = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_SEXT = 2'd2;
    localparam logic [1:0] SRCB_ZEXT = 2'd3;

    localparam logic [1:0] PC_SRC_SEQ = 2'd0;
    localparam logic [1:0] PC_SRC_BR  = 2'd1;

    typedef enum logic [3:0] {
        CL_NOP   = 4'd0,
        CL_RTYPE = 4'd1,
        CL_ADDI  = 4'd2,
        CL_ANDI  = 4'd3,
        CL_LUI   = 4'd4,
        CL_LW    = 4'd5,
        CL_SW    = 4'd6,
        CL_BEQ   = 4'd7,
        CL_BNE   = 4'd8
    } instr_class_t;

endpackage

// File: rtl/mips_mc_control_if.sv
// Control-unit <-> datapath bundle. slave = control unit, master = datapath (or bench).
interface mips_mc_control_if;
    logic       enable;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       alu_zero;
    logic [3:0] state_code;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctrl;
    logic       illegal_op;

    modport slave (
        input  enable, opcode, funct, alu_zero,
        output state_code, ir_write, pc_write, pc_src, iord, mem_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_ctrl, illegal_op
    );

    modport master (
        output enable, opcode, funct, alu_zero,
        input  state_code, ir_write, pc_write, pc_src, iord, mem_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_ctrl, illegal_op
    );
endinterface

// File: rtl/mips_mc_decode.sv
// Combinational opcode/funct -> instruction class and ALU control; shared with the datapath
// ALU decoder. Anything not recognised decodes to CL_NOP.
module mips_mc_decode
    import mips_pkg::*;
(
    input  logic [5:0]   i_opcode,
    input  logic [5:0]   i_funct,
    output instr_class_t o_class,
    output logic [3:0]   o_alu_ctrl
);
    always_comb begin
        o_class    = CL_NOP;
        o_alu_ctrl = ALU_ADD;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADD: begin o_class = CL_RTYPE; o_alu_ctrl = ALU_ADD; end
                    FN_OR:  begin o_class = CL_RTYPE; o_alu_ctrl = ALU_OR;  end
                    FN_SLL: begin o_class = CL_RTYPE; o_alu_ctrl = ALU_SLL; end
                    default: ;
                endcase
            end
            OP_ADDI: begin o_class = CL_ADDI; o_alu_ctrl = ALU_ADD; end
            OP_ANDI: begin o_class = CL_ANDI; o_alu_ctrl = ALU_AND; end
            OP_LUI:  begin o_class = CL_LUI;  o_alu_ctrl = ALU_LUI; end
            OP_LW:   begin o_class = CL_LW;   o_alu_ctrl = ALU_ADD; end
            OP_SW:   begin o_class = CL_SW;   o_alu_ctrl = ALU_ADD; end
            OP_BEQ:  begin o_class = CL_BEQ;  o_alu_ctrl = ALU_SUB; end
            OP_BNE:  begin o_class = CL_BNE;  o_alu_ctrl = ALU_SUB; end
            default: ;
        endcase
    end
endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM: IDLE -> FETCH -> DECODE -> EXEC -> WB/MEM -> DUMMY, Moore strobes.
// Optional MIPS_MC_ILLEGAL_TRAP_EN: sticky illegal_op and halt after an unknown instruction.
module mips_mc_control
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STEPS      = 5
) (
    input  logic             clk,
    input  logic             reset,
    mips_mc_control_if.slave bus
);
    generate
        if (STEPS != 5 || DATA_WIDTH < 16) begin : g_bad_cfg
            $error("mips_mc_control: STEPS must be 5 and DATA_WIDTH at least 16");
        end
    endgenerate

    state_t       r_state, w_next;
    instr_class_t w_class, r_class;
    logic [3:0]   w_alu_ctrl, r_alu_ctrl;
    logic         w_halt;

    mips_mc_decode u_decode (
        .i_opcode   (bus.opcode),
        .i_funct    (bus.funct),
        .o_class    (w_class),
        .o_alu_ctrl (w_alu_ctrl)
    );

    // Decode result is captured leaving DECODE so EXEC..DUMMY don't depend on the IR bus.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_class    <= CL_NOP;
            r_alu_ctrl <= ALU_ADD;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE) begin
                r_class    <= w_class;
                r_alu_ctrl <= w_alu_ctrl;
            end
        end
    end

`ifdef MIPS_MC_ILLEGAL_TRAP_EN
    logic r_illegal;
    logic w_unknown;

    assign w_unknown = (r_state == ST_DECODE) && (w_class == CL_NOP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         r_illegal <= 1'b0;
        else if (w_unknown) r_illegal <= 1'b1;
    end

    assign w_halt         = r_illegal;
    assign bus.illegal_op = r_illegal | w_unknown;
`else
    assign w_halt         = 1'b0;
    assign bus.illegal_op = 1'b0;
`endif

    always_comb begin
        w_next         = r_state;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = PC_SRC_SEQ;
        bus.iord       = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.reg_write  = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = SRCB_RT;
        bus.alu_ctrl   = ALU_ADD;

        case (r_state)
            ST_IDLE: begin
                if (bus.enable && !w_halt) w_next = ST_FETCH;
            end
            ST_FETCH: begin
                bus.ir_write  = 1'b1;
                bus.pc_write  = 1'b1;
                bus.alu_src_b = SRCB_FOUR;
                w_next        = ST_DECODE;
            end
            ST_DECODE: w_next = ST_EXEC;
            ST_EXEC: begin
                w_next = ST_WB;
                if (r_class != CL_NOP) begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_ctrl  = r_alu_ctrl;
                end
                case (r_class)
                    CL_ADDI, CL_LW, CL_SW: bus.alu_src_b = SRCB_SEXT;
                    CL_ANDI, CL_LUI:       bus.alu_src_b = SRCB_ZEXT;
                    CL_BEQ, CL_BNE: begin
                        // Target was formed by the datapath in DECODE; only the select is ours.
                        if ((r_class == CL_BEQ) == bus.alu_zero) begin
                            bus.pc_write = 1'b1;
                            bus.pc_src   = PC_SRC_BR;
                        end
                    end
                    default: ;
                endcase
            end
            ST_WB: begin
                w_next = ST_DUMMY;
                case (r_class)
                    CL_RTYPE: begin bus.reg_write = 1'b1; bus.reg_dst = 1'b1; end
                    CL_ADDI, CL_ANDI, CL_LUI: bus.reg_write = 1'b1;
                    CL_SW: begin bus.mem_write = 1'b1; bus.iord = 1'b1; end
                    CL_LW: bus.iord = 1'b1;
                    default: ;
                endcase
            end
            ST_DUMMY: begin
                w_next = (bus.enable && !w_halt) ? ST_FETCH : ST_IDLE;
                if (r_class == CL_LW) begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign bus.state_code = r_state;

endmodule
